// File: rtl/fft_pkg.sv
`default_nettype none
// fft_pkg: shared defaults, types and index helpers for the FFT output path.
// Rev 1.0
package fft_pkg;

   localparam int FFT_NBITS = 3;
   localparam int FFT_N     = 8;
   localparam int FFT_LOGN  = $clog2(FFT_N);

   typedef logic [2*FFT_NBITS-1:0] sample_t;

   typedef enum logic [0:0] {
      W_WAIT_SOF = 1'b0,
      W_FILL     = 1'b1
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE  = 1'b0,
      R_DRAIN = 1'b1
   } rd_state_t;

   // Reverses the low logn bits of idx; higher bits of the result are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int logn);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < logn) r[i] = idx[logn-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_bank.sv
`default_nettype none
// fft_reorder_bank: N-entry register bank, two write ports, two async read ports.
// Rev 1.0
module fft_reorder_bank #(
   parameter int N    = 8,
   parameter int W    = 6,
   parameter int LOGN = $clog2(N)
) (
   input  logic            clk,
   input  logic            we0,
   input  logic [LOGN-1:0] waddr0,
   input  logic [W-1:0]    wdata0,
   input  logic            we1,
   input  logic [LOGN-1:0] waddr1,
   input  logic [W-1:0]    wdata1,
   input  logic [LOGN-1:0] raddr0,
   output logic [W-1:0]    rdata0,
   input  logic [LOGN-1:0] raddr1,
   output logic [W-1:0]    rdata1
);

   // No reset: contents are only ever read after a full frame was written.
   logic [W-1:0] mem [N];

   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule
`default_nettype wire

// File: rtl/fft_out_reorder.sv
`default_nettype none
// fft_out_reorder: ping-pong buffer turning bit-reversed FFT pairs into natural order.
// Rev 1.0
module fft_out_reorder
   import fft_pkg::*;
#(
   parameter int NBITS = FFT_NBITS,
   parameter int N     = FFT_N,
   parameter int LOGN  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*NBITS-1:0] in_up,
   input  logic [2*NBITS-1:0] in_down,
   input  logic               in_valid,
   input  logic               in_sof,
   output logic [2*NBITS-1:0] out_up,
   output logic [2*NBITS-1:0] out_down,
   output logic               out_valid,
   output logic               out_sof
);

   localparam int W  = 2*NBITS;
   localparam int CW = LOGN-1;
   localparam logic [CW-1:0] LAST = CW'(N/2-1);

   wr_state_t     w_state, w_state_nxt;
   logic [CW-1:0] wcnt, wcnt_nxt, wr_pair;
   logic          wr_en, frame_done;
   logic          wb;
   logic [1:0]    full, full_nxt;

   rd_state_t     r_state, r_state_nxt;
   logic [CW-1:0] rcnt, rcnt_nxt, rd_idx;
   logic          rb, emit, drain_end;

   logic [LOGN-1:0] waddr_up, waddr_dn, raddr_up, raddr_dn;
   logic [W-1:0]    rd_up [2];
   logic [W-1:0]    rd_dn [2];

   // Write side: an sof always restarts the current bank at pair 0.
   always_comb begin
      w_state_nxt = w_state;
      wcnt_nxt    = wcnt;
      wr_pair     = wcnt;
      wr_en       = 1'b0;
      frame_done  = 1'b0;
      case (w_state)
         W_WAIT_SOF: begin
            if (in_valid && in_sof) begin
               wr_en       = 1'b1;
               wr_pair     = '0;
               wcnt_nxt    = CW'(1);
               w_state_nxt = W_FILL;
            end
         end
         W_FILL: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (in_sof) begin
                  wr_pair  = '0;
                  wcnt_nxt = CW'(1);
               end else if (wcnt == LAST) begin
                  frame_done  = 1'b1;
                  wcnt_nxt    = '0;
                  w_state_nxt = W_WAIT_SOF;
               end else begin
                  wcnt_nxt = wcnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = W_WAIT_SOF;
      endcase
   end

   // Read side: idle emits pair 0 as soon as the bank is full, so a bank
   // completed during the last drain cycle follows with no bubble.
   always_comb begin
      r_state_nxt = r_state;
      rcnt_nxt    = rcnt;
      rd_idx      = rcnt;
      emit        = 1'b0;
      drain_end   = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (full[rb]) begin
               emit        = 1'b1;
               rd_idx      = '0;
               rcnt_nxt    = CW'(1);
               r_state_nxt = R_DRAIN;
            end
         end
         R_DRAIN: begin
            emit = 1'b1;
            if (rcnt == LAST) begin
               drain_end   = 1'b1;
               rcnt_nxt    = '0;
               r_state_nxt = R_IDLE;
            end else begin
               rcnt_nxt = rcnt + 1'b1;
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      full_nxt = full;
      if (drain_end)  full_nxt[rb] = 1'b0;
      if (frame_done) full_nxt[wb] = 1'b1;
   end

   assign waddr_up = LOGN'(bitrev(32'({wr_pair, 1'b0}), LOGN));
   assign waddr_dn = LOGN'(bitrev(32'({wr_pair, 1'b1}), LOGN));
   assign raddr_up = {rd_idx, 1'b0};
   assign raddr_dn = {rd_idx, 1'b1};

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_reorder_bank #(.N(N), .W(W), .LOGN(LOGN)) u_bank (
         .clk    (clk),
         .we0    (wr_en && (wb == b[0])),
         .waddr0 (waddr_up),
         .wdata0 (in_up),
         .we1    (wr_en && (wb == b[0])),
         .waddr1 (waddr_dn),
         .wdata1 (in_down),
         .raddr0 (raddr_up),
         .rdata0 (rd_up[b]),
         .raddr1 (raddr_dn),
         .rdata1 (rd_dn[b])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_WAIT_SOF;
         wcnt      <= '0;
         wb        <= 1'b0;
         full      <= 2'b00;
         r_state   <= R_IDLE;
         rcnt      <= '0;
         rb        <= 1'b0;
         out_up    <= '0;
         out_down  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
      end else begin
         w_state   <= w_state_nxt;
         wcnt      <= wcnt_nxt;
         r_state   <= r_state_nxt;
         rcnt      <= rcnt_nxt;
         full      <= full_nxt;
         if (frame_done) wb <= ~wb;
         if (drain_end)  rb <= ~rb;
         out_valid <= emit;
         out_sof   <= emit && (rd_idx == '0);
         out_up    <= emit ? rd_up[rb] : '0;
         out_down  <= emit ? rd_dn[rb] : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
`default_nettype none
// tb_fft_out_reorder: randomized bench against a frame-level reference model.
// Rev 1.0
module tb_fft_out_reorder;

   localparam int NBITS = 3;
   localparam int N     = 8;
   localparam int LOGN  = 3;
   localparam int W     = 2*NBITS;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_up, in_down, out_up, out_down;
   logic         in_valid, in_sof, out_valid, out_sof;

   int n_cmp = 0;
   int n_bad = 0;

   fft_out_reorder #(.NBITS(NBITS), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_up     (in_up),
      .in_down   (in_down),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .out_up    (out_up),
      .out_down  (out_down),
      .out_valid (out_valid),
      .out_sof   (out_sof)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [2*W+1:0] got, input logic [2*W+1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got {v,sof,up,dn}=%h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic int br(input int v);
      int r = 0;
      for (int i = 0; i < LOGN; i++) if (v[i]) r |= 1 << (LOGN-1-i);
      return r;
   endfunction

   // Reference model: frames assembled by natural index, then replayed as a stream.
   logic [W-1:0] part [N];
   logic [W-1:0] cur  [N];
   logic [W-1:0] fq[$];
   int           mw = 0;
   bit           filling = 0;
   int           dpos = -1;
   logic [2*W+1:0] exp_out;

   always @(posedge clk) begin
      exp_out = '0;
      if (rst) begin
         filling = 0;
         mw      = 0;
         dpos    = -1;
         fq.delete();
      end else begin
         if (dpos < 0 && fq.size() >= N) begin
            for (int i = 0; i < N; i++) cur[i] = fq.pop_front();
            dpos = 0;
         end
         if (dpos >= 0) begin
            exp_out = {1'b1, dpos == 0, cur[2*dpos], cur[2*dpos+1]};
            dpos++;
            if (dpos == N/2) dpos = -1;
         end
         if (in_valid && (in_sof || filling)) begin
            if (in_sof) mw = 0;
            part[br(2*mw)]   = in_up;
            part[br(2*mw+1)] = in_down;
            mw++;
            filling = 1;
            if (mw == N/2) begin
               for (int i = 0; i < N; i++) fq.push_back(part[i]);
               filling = 0;
               mw      = 0;
            end
         end
      end
      #1 check_eq("out", {out_valid, out_sof, out_up, out_down}, exp_out);
   end

   task automatic put(input logic [W-1:0] u, input logic [W-1:0] d, input logic s);
      @(negedge clk);
      in_up = u; in_down = d; in_valid = 1'b1; in_sof = s;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0; in_sof = 1'b0;
         in_up = W'($urandom); in_down = W'($urandom);
      end
   endtask

   // gap < 0 selects a random 0..2 cycle gap after every pair.
   task automatic frame(input int base, input int gap, input bit rnd, input int npairs);
      for (int k = 0; k < npairs; k++) begin
         if (rnd) put(W'($urandom), W'($urandom), k == 0);
         else     put(W'(base + br(2*k)), W'(base + br(2*k+1)), k == 0);
         idle(gap < 0 ? int'($urandom_range(0, 2)) : gap);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_up = '0; in_down = '0;
      idle(3);
      rst = 1'b0;
      idle(2);
      frame(0, 0, 0, N/2); idle(6);
      frame(0, 0, 0, N/2); frame(8, 0, 0, N/2); idle(10);
      frame(0, 2, 0, N/2); idle(6);
      repeat (3) put(W'(5), W'(5), 1'b0);
      idle(4);
      frame(0, 0, 0, 2); frame(16, 0, 0, N/2); idle(8);
      frame(0, 0, 0, N/2); idle(1);
      @(negedge clk); rst = 1'b1; in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      idle(8);
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0: begin
               repeat ($urandom_range(1, 3)) put(W'($urandom), W'($urandom), 1'b0);
            end
            1: frame(0, -1, 1, int'($urandom_range(1, N/2-1)));
            2: begin
               @(negedge clk); rst = 1'b1; in_valid = 1'b0;
               @(negedge clk); rst = 1'b0;
            end
            default: frame(0, ($urandom_range(0, 1) == 0) ? 0 : -1, 1, N/2);
         endcase
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(12);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
